// File: rtl/data_sram_responder.sv
// data_sram_responder: turns each CPU data-port access into exactly one req/ack bus transaction per stall window
module data_sram_responder #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_sram_en,
  input  logic [DW/8-1:0]  data_sram_wen,
  input  logic [AW-1:0]    data_sram_addr,
  input  logic [DW-1:0]    data_sram_wdata,
  input  logic             no_dcache,
  input  logic             longest_stall,
  output logic [DW-1:0]    data_sram_rdata,
  output logic             data_stall,
  output logic             mem_req,
  output logic             mem_wr,
  output logic             mem_uncached,
  output logic [AW-1:0]    mem_addr,
  output logic [DW/8-1:0]  mem_wstrb,
  output logic [DW-1:0]    mem_wdata,
  input  logic             mem_ack,
  input  logic [DW-1:0]    mem_rdata,
  output logic [CNT_W-1:0] stall_cycles
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state;
  assign data_stall = (state == IDLE && data_sram_en) || state == REQ;
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      mem_req         <= 1'b0;
      mem_wr          <= 1'b0;
      mem_uncached    <= 1'b0;
      mem_addr        <= '0;
      mem_wstrb       <= '0;
      mem_wdata       <= '0;
      data_sram_rdata <= '0;
      stall_cycles    <= '0;
    end else begin
      if (data_stall && !(&stall_cycles)) stall_cycles <= stall_cycles + CNT_W'(1);
      if (state == IDLE && data_sram_en) begin
        state        <= REQ;
        mem_req      <= 1'b1;
        mem_wr       <= |data_sram_wen;
        mem_uncached <= no_dcache;
        mem_addr     <= data_sram_addr;
        mem_wstrb    <= data_sram_wen;
        mem_wdata    <= data_sram_wdata;
      end else if (state == REQ && mem_ack) begin
        state   <= DONE;
        mem_req <= 1'b0;
        if (!mem_wr) data_sram_rdata <= mem_rdata;
      end else if (state == DONE && !longest_stall) begin
        // served access stays parked until the pipeline actually advances
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_data_sram_responder.sv
// tb_data_sram_responder: directed plus randomized transactions checked against a transaction-level model
module tb_data_sram_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        no_dcache;
  logic        longest_stall;
  logic [31:0] data_sram_rdata;
  logic        data_stall;
  logic        mem_req;
  logic        mem_wr;
  logic        mem_uncached;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] stall_cycles;

  int total = 0;
  int bad = 0;
  int edges = 0;
  int exp_txn = 0;
  longint exp_stall = 0;
  logic [31:0] exp_rdata = '0;
  logic prev_req = 1'b0;

  data_sram_responder dut (
    .clk(clk), .rst(rst), .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata), .no_dcache(no_dcache),
    .longest_stall(longest_stall), .data_sram_rdata(data_sram_rdata), .data_stall(data_stall),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_uncached(mem_uncached), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_req && !prev_req) edges++;
    prev_req = mem_req;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input logic [31:0] a, input logic [3:0] w, input logic [31:0] wd,
                     input logic nc, input int d, input int hold, input logic [31:0] rd);
    data_sram_en = 1'b1; data_sram_wen = w; data_sram_addr = a; data_sram_wdata = wd;
    no_dcache = nc; longest_stall = 1'b1;
    #1 check("stall_idle_en", {63'd0, data_stall}, 64'd1);
    step();
    check("req_up", {63'd0, mem_req}, 64'd1);
    check("req_wr", {63'd0, mem_wr}, {63'd0, |w});
    check("req_addr", {32'd0, mem_addr}, {32'd0, a});
    check("req_wstrb", {60'd0, mem_wstrb}, {60'd0, w});
    check("req_wdata", {32'd0, mem_wdata}, {32'd0, wd});
    check("req_uncached", {63'd0, mem_uncached}, {63'd0, nc});
    data_sram_en = 1'($urandom); data_sram_wen = 4'($urandom);
    data_sram_addr = $urandom; data_sram_wdata = $urandom; no_dcache = 1'($urandom);
    repeat (d) begin
      check("stall_req", {63'd0, data_stall}, 64'd1);
      step();
      check("req_hold_addr", {32'd0, mem_addr}, {32'd0, a});
    end
    mem_ack = 1'b1; mem_rdata = rd;
    step();
    mem_ack = 1'b0; mem_rdata = $urandom;
    if (w == 4'd0) exp_rdata = rd;
    exp_stall += d + 2;
    exp_txn++;
    check("done_stall", {63'd0, data_stall}, 64'd0);
    check("done_req", {63'd0, mem_req}, 64'd0);
    check("done_rdata", {32'd0, data_sram_rdata}, {32'd0, exp_rdata});
    check("stall_count", {32'd0, stall_cycles}, exp_stall[63:0]);
    check("req_edges", 64'(edges), 64'(exp_txn));
    data_sram_en = 1'b1;
    repeat (hold) begin
      mem_ack = 1'($urandom); mem_rdata = $urandom;
      step();
      check("hold_req", {63'd0, mem_req}, 64'd0);
      check("hold_stall", {63'd0, data_stall}, 64'd0);
      check("hold_rdata", {32'd0, data_sram_rdata}, {32'd0, exp_rdata});
    end
    mem_ack = 1'b0; longest_stall = 1'b0;
    step();
    data_sram_en = 1'b0;
    check("hold_edges", 64'(edges), 64'(exp_txn));
  endtask

  initial begin
    rst = 1'b1; data_sram_en = 1'b0; data_sram_wen = '0; data_sram_addr = '0; data_sram_wdata = '0;
    no_dcache = 1'b0; longest_stall = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    step(); step();
    check("rst_req", {63'd0, mem_req}, 64'd0);
    check("rst_stall", {63'd0, data_stall}, 64'd0);
    check("rst_rdata", {32'd0, data_sram_rdata}, 64'd0);
    check("rst_addr", {32'd0, mem_addr}, 64'd0);
    check("rst_count", {32'd0, stall_cycles}, 64'd0);
    rst = 1'b0;
    step();
    txn(32'h1FC0_0010, 4'b0000, 32'h0, 1'b0, 2, 0, 32'hDEAD_BEEF);
    check("t1_stall4", {32'd0, stall_cycles}, 64'd4);
    txn(32'h0000_0101, 4'b0100, 32'h00AB_0000, 1'b0, 0, 0, $urandom);
    check("t2_rdata_kept", {32'd0, data_sram_rdata}, 64'hDEAD_BEEF);
    txn($urandom, 4'b0000, $urandom, 1'b0, 1, 5, $urandom);
    mem_ack = 1'b1; mem_rdata = $urandom;
    step();
    mem_ack = 1'b0;
    check("idle_ack_req", {63'd0, mem_req}, 64'd0);
    check("idle_ack_rdata", {32'd0, data_sram_rdata}, {32'd0, exp_rdata});
    for (int i = 0; i < 20; i++)
      txn($urandom, ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom), $urandom, 1'($urandom),
          $urandom_range(0, 4), $urandom_range(0, 3), $urandom);
    data_sram_en = 1'b1; data_sram_wen = '0; data_sram_addr = $urandom; no_dcache = 1'b1;
    longest_stall = 1'b1;
    step();
    check("t5_uncached", {63'd0, mem_uncached}, 64'd1);
    check("t5_req", {63'd0, mem_req}, 64'd1);
    rst = 1'b1; data_sram_en = 1'b0;
    step();
    check("t5_rst_req", {63'd0, mem_req}, 64'd0);
    check("t5_rst_stall", {63'd0, data_stall}, 64'd0);
    check("t5_rst_rdata", {32'd0, data_sram_rdata}, 64'd0);
    check("t5_rst_count", {32'd0, stall_cycles}, 64'd0);
    rst = 1'b0; longest_stall = 1'b0;
    exp_stall = 0; exp_rdata = '0;
    step();
    exp_txn = edges;
    txn($urandom, 4'b0000, $urandom, 1'b0, 0, 0, $urandom);
    txn($urandom, 4'b0000, $urandom, 1'b0, 0, 0, $urandom);
    check("t4_stall4", {32'd0, stall_cycles}, 64'd4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
